// File: rtl/ibex_pkg.sv
// Shared types for the branch-resolve slice: the prediction entry and
// the fall-through PC helper used by the compare logic.
package ibex_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        compressed;
        logic        taken;
        logic [31:0] target;
    } bp_entry_t;

    function automatic logic [31:0] bp_fall_through(input logic [31:0] pc,
                                                    input logic        compressed);
        return pc + (compressed ? 32'd2 : 32'd4);
    endfunction

endpackage

// File: rtl/ibex_branch_resolve_fifo.sv
// In-order buffer of in-flight branch predictions; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module ibex_branch_resolve_fifo
    import ibex_pkg::*;
#(
    parameter int  Depth   = 4,
    parameter type entry_t = bp_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    input  logic   clear,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(Depth);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    entry_t      mem [Depth];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // clear wins over push/pop so a discarded window can never leave a
    // half-updated pointer pair behind.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; entries are only ever read
    // between a push and the matching pop, so resetting it buys nothing.
    always_ff @(posedge clk_i) begin
        if (push && !full && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ibex_branch_resolve.sv
// Checks static branch predictions against execute's resolved outcomes and
// produces a registered fetch redirect on disagreement, plus statistics.
module ibex_branch_resolve
    import ibex_pkg::*;
#(
    parameter int Depth    = 4,
    parameter int CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pred_valid_i,
    output logic                pred_ready_o,
    input  logic [31:0]         pred_pc_i,
    input  logic                pred_compressed_i,
    input  logic                pred_taken_i,
    input  logic [31:0]         pred_target_i,
    input  logic                res_valid_i,
    input  logic [31:0]         res_pc_i,
    input  logic                res_taken_i,
    input  logic [31:0]         res_target_i,
    input  logic                flush_i,
    output logic                mispredict_o,
    output logic [31:0]         redirect_pc_o,
    output logic                err_o,
    output logic [CntWidth-1:0] stat_resolved_o,
    output logic [CntWidth-1:0] stat_mispredict_o
);

    logic        full;
    logic        empty;
    bp_entry_t   head;
    bp_entry_t   wdata;
    logic        push;
    logic        pop;
    logic        clear;
    logic        mis_now;
    logic [31:0] fall;
    logic [31:0] pnext;
    logic [31:0] anext;

    assign wdata = '{pc: pred_pc_i, compressed: pred_compressed_i,
                     taken: pred_taken_i, target: pred_target_i};

    assign pred_ready_o = !full;
    assign pop          = res_valid_i && !empty && !flush_i;

    // NOTE: pure combinational logic lives in always_comb with blocking
    // assignments and a default for every output, so no latch is inferred.
    always_comb begin
        fall    = bp_fall_through(head.pc, head.compressed);
        pnext   = head.taken ? head.target : fall;
        anext   = res_taken_i ? res_target_i : fall;
        mis_now = 1'b0;
        if (pop) mis_now = (pnext != anext);
    end

    // A mispredict squashes everything younger, including this cycle's push.
    assign clear = flush_i || mis_now;
    assign push  = pred_valid_i && pred_ready_o && !clear;

    ibex_branch_resolve_fifo #(
        .Depth   (Depth),
        .entry_t (bp_entry_t)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .clear (clear),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            err_o         <= 1'b0;
        end else begin
            mispredict_o <= mis_now;
            if (mis_now) redirect_pc_o <= anext;
            if ((res_valid_i && empty && !flush_i) ||
                (pop && (res_pc_i != head.pc))) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_resolved_o   <= '0;
            stat_mispredict_o <= '0;
        end else begin
            if (pop && (stat_resolved_o != '1)) begin
                stat_resolved_o <= stat_resolved_o + CntWidth'(1);
            end
            if (mis_now && (stat_mispredict_o != '1)) begin
                stat_mispredict_o <= stat_mispredict_o + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Directed bench for ibex_branch_resolve: a per-cycle vector table plus
// hand-written sequences for back-pressure and counter saturation.
module tb_ibex_branch_resolve;

    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          pred_valid;
    logic          pred_ready;
    logic [31:0]   pred_pc;
    logic          pred_compressed;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          res_valid;
    logic [31:0]   res_pc;
    logic          res_taken;
    logic [31:0]   res_target;
    logic          flush;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic          err;
    logic [CW-1:0] stat_resolved;
    logic [CW-1:0] stat_mispredict;

    int errors = 0;
    int checks = 0;

    ibex_branch_resolve #(.Depth(4), .CntWidth(CW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .pred_valid_i      (pred_valid),
        .pred_ready_o      (pred_ready),
        .pred_pc_i         (pred_pc),
        .pred_compressed_i (pred_compressed),
        .pred_taken_i      (pred_taken),
        .pred_target_i     (pred_target),
        .res_valid_i       (res_valid),
        .res_pc_i          (res_pc),
        .res_taken_i       (res_taken),
        .res_target_i      (res_target),
        .flush_i           (flush),
        .mispredict_o      (mispredict),
        .redirect_pc_o     (redirect_pc),
        .err_o             (err),
        .stat_resolved_o   (stat_resolved),
        .stat_mispredict_o (stat_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        pv;
        logic [31:0] ppc;
        logic        pcc;
        logic        pt;
        logic [31:0] ptgt;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtgt;
        logic        fl;
        logic        e_ready;
        logic        e_mis;
        logic [31:0] e_redir;
        logic        e_err;
        int          e_res;
        int          e_misc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic pv, input logic [31:0] ppc,
                       input logic pcc, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic [31:0] rpc, input logic rt,
                       input logic [31:0] rtgt, input logic fl,
                       input logic e_ready, input logic e_mis, input logic [31:0] e_redir,
                       input logic e_err, input int e_res, input int e_misc);
        vec_t v;
        v = '{r, pv, ppc, pcc, pt, ptgt, rv, rpc, rt, rtgt, fl,
              e_ready, e_mis, e_redir, e_err, e_res, e_misc};
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs away from the edge, then sample #1 after it.
    task automatic cyc(input logic r, input logic pv, input logic [31:0] ppc,
                       input logic pcc, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic [31:0] rpc, input logic rt,
                       input logic [31:0] rtgt, input logic fl);
        @(negedge clk);
        rst = r; pred_valid = pv; pred_pc = ppc; pred_compressed = pcc;
        pred_taken = pt; pred_target = ptgt; res_valid = rv; res_pc = rpc;
        res_taken = rt; res_target = rtgt; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_ready, input logic e_mis,
                             input logic [31:0] e_redir, input logic e_err,
                             input int e_res, input int e_misc);
        check({tag, "_ready"},    32'(pred_ready),      32'(e_ready));
        check({tag, "_mis"},      32'(mispredict),      32'(e_mis));
        check({tag, "_redirect"}, redirect_pc,          e_redir);
        check({tag, "_err"},      32'(err),             32'(e_err));
        check({tag, "_resolved"}, 32'(stat_resolved),   32'(e_res));
        check({tag, "_mispcnt"},  32'(stat_mispredict), 32'(e_misc));
    endtask

    initial begin
        rst = 1'b1; pred_valid = 0; pred_pc = 0; pred_compressed = 0;
        pred_taken = 0; pred_target = 0; res_valid = 0; res_pc = 0;
        res_taken = 0; res_target = 0; flush = 0;

        //   rst pv ppc           c  t  ptgt     rv rpc           rt rtgt     fl  rdy mis redir        err res misc
        add(1, 0, 0,            0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0); // reset
        add(0, 1, 'h100,        0, 1, 'hF0,    0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 0, 0,            0, 0, 0,       1, 'h100,        1, 'hF0,    0,  1, 0, 0,           0, 1, 0); // correct taken
        add(0, 1, 'h200,        1, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 1, 0);
        add(0, 0, 0,            0, 0, 0,       1, 'h200,        1, 'h300,   0,  1, 1, 'h300,       0, 2, 1); // NT->T
        add(0, 0, 0,            0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 'h300,       0, 2, 1); // pulse ends
        add(0, 1, 'h400,        0, 1, 'h380,   0, 0,            0, 0,       0,  1, 0, 'h300,       0, 2, 1);
        add(0, 1, 'h410,        0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 'h300,       0, 2, 1);
        add(0, 1, 'h420,        0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 'h300,       0, 2, 1);
        add(0, 1, 'h430,        0, 0, 0,       1, 'h400,        0, 0,       0,  1, 1, 'h404,       0, 3, 2); // T->NT, push dropped
        add(0, 0, 0,            0, 0, 0,       1, 'h410,        0, 0,       0,  1, 0, 'h404,       1, 3, 2); // resolve on empty
        add(0, 0, 0,            0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 'h404,       1, 3, 2); // err sticky
        add(0, 1, 'h600,        0, 1, 'h700,   0, 0,            0, 0,       0,  1, 0, 'h404,       1, 3, 2);
        add(0, 1, 'h610,        0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 'h404,       1, 3, 2);
        add(1, 1, 'h620,        0, 0, 0,       1, 'h600,        0, 0,       0,  1, 0, 0,           0, 0, 0); // reset mid-run
        add(0, 1, 'h500,        0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 0, 0,            0, 0, 0,       1, 'h504,        0, 0,       0,  1, 0, 0,           1, 1, 0); // pc mismatch, pop
        add(1, 0, 0,            0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 1, 'h800,        0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 1, 'h810,        0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 1, 'h820,        0, 0, 0,       1, 'h800,        1, 'h999,   1,  1, 0, 0,           0, 0, 0); // flush
        add(0, 0, 0,            0, 0, 0,       1, 'h800,        1, 'h999,   0,  1, 0, 0,           1, 0, 0); // now empty
        add(1, 0, 0,            0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 1, 'hFFFF_FFFC,  0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 0, 0);
        add(0, 0, 0,            0, 0, 0,       1, 'hFFFF_FFFC,  1, 'h40,    0,  1, 1, 'h40,        0, 1, 1);
        add(0, 1, 'hFFFF_FFFE,  1, 1, 'h80,    0, 0,            0, 0,       0,  1, 0, 'h40,        0, 1, 1);
        add(0, 0, 0,            0, 0, 0,       1, 'hFFFF_FFFE,  0, 0,       0,  1, 1, 0,           0, 2, 2); // wraps to 0
        add(0, 1, 'hFFFF_FFFC,  0, 0, 0,       0, 0,            0, 0,       0,  1, 0, 0,           0, 2, 2);
        add(0, 0, 0,            0, 0, 0,       1, 'hFFFF_FFFC,  0, 0,       0,  1, 0, 0,           0, 3, 2); // both NT
        add(0, 1, 'h900,        0, 1, 'hA00,   0, 0,            0, 0,       0,  1, 0, 0,           0, 3, 2);
        add(0, 0, 0,            0, 0, 0,       1, 'h900,        1, 'hA04,   0,  1, 1, 'hA04,       0, 4, 3); // wrong target
        add(0, 1, 'h910,        0, 1, 'hA00,   0, 0,            0, 0,       0,  1, 0, 'hA04,       0, 4, 3);
        add(0, 0, 0,            0, 0, 0,       1, 'h910,        1, 'hA00,   0,  1, 0, 'hA04,       0, 5, 3);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].pv, vecs[i].ppc, vecs[i].pcc, vecs[i].pt, vecs[i].ptgt,
                vecs[i].rv, vecs[i].rpc, vecs[i].rt, vecs[i].rtgt, vecs[i].fl);
            check_all($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_mis, vecs[i].e_redir,
                      vecs[i].e_err, vecs[i].e_res, vecs[i].e_misc);
        end

        // Back-pressure: fill, hold a fifth push, no bypass on the popping cycle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'hC00 + 32'(4*i), 0, 0, 0, 0, 0, 0, 0, 0);
        check("full_ready", 32'(pred_ready), 32'd0);
        cyc(0, 1, 'hD00, 0, 0, 0, 0, 0, 0, 0, 0);
        check("held_ready", 32'(pred_ready), 32'd0);
        cyc(0, 1, 'hD00, 0, 0, 0, 1, 'hC00, 0, 0, 0);
        check("nobypass_ready", 32'(pred_ready), 32'd1);
        check("nobypass_mis", 32'(mispredict), 32'd0);
        cyc(0, 1, 'hD00, 0, 0, 0, 0, 0, 0, 0, 0);
        check("accept_ready", 32'(pred_ready), 32'd0);
        for (int i = 1; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 32'hC00 + 32'(4*i), 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 'hD00, 0, 0, 0);
        check_all("drain", 1, 0, 0, 0, 5, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 'hD00, 0, 0, 0);
        check("drained_err", 32'(err), 32'd1);

        // Counter saturation, with push and correct pop in the same cycle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 'hE00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 'hE00, 0, 0, 0, 1, 'hE00, 0, 0, 0);
        check_all("sat_res", 1, 0, 0, 0, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 'hE00, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 'hF00, 0, 1, 'h50, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 1, 'hF00, 0, 0, 0);
        end
        check_all("sat_mis", 1, 1, 'hF04, 0, 7, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
